// File: rtl/vid_tracker.sv
// vid_tracker: two-stage video pipeline that adds pixel and line coordinates,
// start-of-line/start-of-frame strobes and a running measurement of the active
// resolution, with a stability indicator and a sticky saturation flag.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   de_i, hs_i, vs_i, d_i     incoming video timing and pixel data
//   de_o, hs_o, vs_o, d_o     the same, delayed by two cycles
//   x_o, y_o                  pixel / active-line index of the pixel on d_o
//   sol_o, sof_o              start-of-line / start-of-frame strobes (with de_o)
//   h_act_o, v_act_o          measured active pixels per line / lines per frame
//   stable_o                  measurement repeated STABLE_FRAMES times
//   ovf_o                     sticky: a counter hit its ceiling
module vid_tracker #(
  parameter int WIDTH         = 24,
  parameter int XW            = 12,
  parameter int YW            = 12,
  parameter int STABLE_FRAMES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             de_i,
  input  logic             hs_i,
  input  logic             vs_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             de_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic [WIDTH-1:0] d_o,
  output logic [XW-1:0]    x_o,
  output logic [YW-1:0]    y_o,
  output logic             sol_o,
  output logic             sof_o,
  output logic [XW-1:0]    h_act_o,
  output logic [YW-1:0]    v_act_o,
  output logic             stable_o,
  output logic             ovf_o
);

  localparam logic [XW-1:0] X_MAX = '1;
  localparam logic [YW-1:0] Y_MAX = '1;
  localparam logic [3:0]    SF    = 4'(STABLE_FRAMES);

  logic             de1, hs1, vs1;
  logic [WIDTH-1:0] d1;
  logic [YW-1:0]    line_cnt;
  logic [XW-1:0]    line_len;
  logic             sof_pend;
  logic [3:0]       stab_cnt;

  logic             de_rise, de_fall, vs_rise;
  logic             x_full, y_full;
  logic [XW-1:0]    len_done, new_h;
  logic [YW-1:0]    new_v, y_eff;
  logic             sof_hit, same_meas, ovf_set;
  logic [3:0]       stab_next;

  // Stage-2 outputs double as the edge history of stage 1, so edges are only
  // ever seen on registered data and both history bits clear with reset.
  always_comb begin
    de_rise  = de1 & ~de_o;
    de_fall  = ~de1 & de_o;
    vs_rise  = vs1 & ~vs_o;
    x_full   = (x_o == X_MAX);
    y_full   = (line_cnt == Y_MAX);
    // On a falling edge x_o still holds the last pixel index of the line.
    len_done = x_full ? X_MAX : x_o + XW'(1);
    // A line ending on the vs edge still belongs to the frame being closed.
    new_h    = de_fall ? len_done : line_len;
    new_v    = de_fall ? (y_full ? Y_MAX : line_cnt + YW'(1)) : line_cnt;
    // vs wins over a coincident de rise: that line is already line 0.
    y_eff    = vs_rise ? '0 : line_cnt;
    sof_hit  = de_rise & (vs_rise | sof_pend) & (y_eff == '0);
    same_meas = (new_h == h_act_o) && (new_v == v_act_o) &&
                (new_h != '0) && (new_v != '0);
    stab_next = stab_cnt;
    if (vs_rise)
      stab_next = same_meas ? ((stab_cnt == 4'hF) ? 4'hF : stab_cnt + 4'd1) : 4'd0;
    ovf_set  = (de1 & de_o & x_full) | (de_fall & (x_full | y_full));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      de1      <= 1'b0;
      hs1      <= 1'b0;
      vs1      <= 1'b0;
      d1       <= '0;
      de_o     <= 1'b0;
      hs_o     <= 1'b0;
      vs_o     <= 1'b0;
      d_o      <= '0;
      x_o      <= '0;
      y_o      <= '0;
      sol_o    <= 1'b0;
      sof_o    <= 1'b0;
      h_act_o  <= '0;
      v_act_o  <= '0;
      stable_o <= 1'b0;
      ovf_o    <= 1'b0;
      line_cnt <= '0;
      line_len <= '0;
      sof_pend <= 1'b0;
      stab_cnt <= 4'd0;
    end else begin
      de1   <= de_i;
      hs1   <= hs_i;
      vs1   <= vs_i;
      d1    <= d_i;
      de_o  <= de1;
      hs_o  <= hs1;
      vs_o  <= vs1;
      d_o   <= d1;
      sol_o <= de_rise;
      sof_o <= sof_hit;
      y_o   <= y_eff;

      if (de_rise)
        x_o <= '0;
      else if (de1 && !x_full)
        x_o <= x_o + XW'(1);

      if (vs_rise) begin
        h_act_o  <= new_h;
        v_act_o  <= new_v;
        line_cnt <= '0;
      end else if (de_fall && !y_full) begin
        line_cnt <= line_cnt + YW'(1);
      end

      if (de_fall)
        line_len <= len_done;

      // Armed by vs, consumed by the first line-0 pixel of the frame.
      sof_pend <= sof_hit ? 1'b0 : (vs_rise | sof_pend);
      stab_cnt <= stab_next;
      stable_o <= (stab_next >= SF);

      if (ovf_set)
        ovf_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vid_tracker.sv
// Bench for vid_tracker: a default-width instance and a narrow (XW=YW=3)
// instance share one stimulus stream; a frame-level reference model predicts
// every output each cycle, and directed scenarios pin literal values.
module tb_vid_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        de, hs, vs;
  logic [23:0] d;

  logic        de_a, hs_a, vs_a, sol_a, sof_a, stab_a, ovf_a;
  logic [23:0] d_a;
  logic [11:0] x_a, y_a, h_a, v_a;
  logic        de_b, hs_b, vs_b, sol_b, sof_b, stab_b, ovf_b;
  logic [23:0] d_b;
  logic [2:0]  x_b, y_b, h_b, v_b;

  vid_tracker u_a (
    .clk_i(clk), .rst_i(rst), .de_i(de), .hs_i(hs), .vs_i(vs), .d_i(d),
    .de_o(de_a), .hs_o(hs_a), .vs_o(vs_a), .d_o(d_a), .x_o(x_a), .y_o(y_a),
    .sol_o(sol_a), .sof_o(sof_a), .h_act_o(h_a), .v_act_o(v_a),
    .stable_o(stab_a), .ovf_o(ovf_a));

  vid_tracker #(.WIDTH(24), .XW(3), .YW(3), .STABLE_FRAMES(2)) u_b (
    .clk_i(clk), .rst_i(rst), .de_i(de), .hs_i(hs), .vs_i(vs), .d_i(d),
    .de_o(de_b), .hs_o(hs_b), .vs_o(vs_b), .d_o(d_b), .x_o(x_b), .y_o(y_b),
    .sol_o(sol_b), .sof_o(sof_b), .h_act_o(h_b), .v_act_o(v_b),
    .stable_o(stab_b), .ovf_o(ovf_b));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Sample history: h1 = sample one edge ago, h2 = two edges ago.
  bit        h1_de, h1_hs, h1_vs, h2_de, h2_hs, h2_vs;
  bit [23:0] h1_d;
  bit        e_de, e_hs, e_vs;
  bit [23:0] e_d;
  int mx[2] = '{4095, 7};
  int my[2] = '{4095, 7};
  int m_x[2], m_y[2], m_lines[2], m_len[2], m_h[2], m_v[2], m_cnt[2];
  bit m_pend[2], m_ovf[2], m_sol[2], m_sof[2], m_stab[2];

  task automatic model_reset();
    {h1_de, h1_hs, h1_vs, h2_de, h2_hs, h2_vs} = '0;
    h1_d = '0; {e_de, e_hs, e_vs} = '0; e_d = '0;
    for (int i = 0; i < 2; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_lines[i] = 0; m_len[i] = 0; m_h[i] = 0;
      m_v[i] = 0; m_cnt[i] = 0; m_pend[i] = 0; m_ovf[i] = 0; m_sol[i] = 0;
      m_sof[i] = 0; m_stab[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    bit vr, dr, df;
    int y_eff, comp, newh, newv;
    vr = h1_vs && !h2_vs;
    dr = h1_de && !h2_de;
    df = !h1_de && h2_de;
    y_eff = vr ? 0 : m_lines[i];
    m_sol[i] = dr;
    m_sof[i] = dr && (vr || m_pend[i]) && (y_eff == 0);
    m_pend[i] = m_sof[i] ? 1'b0 : (vr || m_pend[i]);
    m_y[i] = y_eff;
    comp = m_x[i] + 1;
    if (df && comp > mx[i]) begin comp = mx[i]; m_ovf[i] = 1; end
    if (dr) m_x[i] = 0;
    else if (h1_de) begin
      if (m_x[i] == mx[i]) m_ovf[i] = 1; else m_x[i]++;
    end
    if (vr) begin
      newh = df ? comp : m_len[i];
      newv = m_lines[i] + (df ? 1 : 0);
      if (newv > my[i]) begin newv = my[i]; m_ovf[i] = 1; end
      if (newh == m_h[i] && newv == m_v[i] && newh != 0 && newv != 0)
        m_cnt[i] = (m_cnt[i] < 15) ? m_cnt[i] + 1 : 15;
      else
        m_cnt[i] = 0;
      m_h[i] = newh; m_v[i] = newv; m_lines[i] = 0;
    end else if (df) begin
      if (m_lines[i] == my[i]) m_ovf[i] = 1; else m_lines[i]++;
    end
    if (df) m_len[i] = comp;
    m_stab[i] = (m_cnt[i] >= 2);
  endtask

  always @(posedge clk) begin
    if (rst) model_reset();
    else begin
      for (int i = 0; i < 2; i++) model_step(i);
      e_de = h1_de; e_hs = h1_hs; e_vs = h1_vs; e_d = h1_d;
      h2_de = h1_de; h2_hs = h1_hs; h2_vs = h1_vs;
      h1_de = de; h1_hs = hs; h1_vs = vs; h1_d = d;
    end
  end

  task automatic check_inst(input int i, input bit z, input bit a_de, a_hs,
                            a_vs, input longint a_d, a_x, a_y,
                            input bit a_sol, a_sof, input longint a_h, a_v,
                            input bit a_st, a_ov);
    chk($sformatf("de[%0d]", i), a_de, z ? 0 : e_de);
    chk($sformatf("hs[%0d]", i), a_hs, z ? 0 : e_hs);
    chk($sformatf("vs[%0d]", i), a_vs, z ? 0 : e_vs);
    chk($sformatf("d[%0d]", i), a_d, z ? 0 : e_d);
    chk($sformatf("sol[%0d]", i), a_sol, z ? 0 : m_sol[i]);
    chk($sformatf("sof[%0d]", i), a_sof, z ? 0 : m_sof[i]);
    chk($sformatf("h_act[%0d]", i), a_h, z ? 0 : m_h[i]);
    chk($sformatf("v_act[%0d]", i), a_v, z ? 0 : m_v[i]);
    chk($sformatf("stable[%0d]", i), a_st, z ? 0 : m_stab[i]);
    chk($sformatf("ovf[%0d]", i), a_ov, z ? 0 : m_ovf[i]);
    if (z || e_de) begin
      chk($sformatf("x[%0d]", i), a_x, z ? 0 : m_x[i]);
      chk($sformatf("y[%0d]", i), a_y, z ? 0 : m_y[i]);
    end
  endtask

  always @(negedge clk) begin
    check_inst(0, rst, de_a, hs_a, vs_a, d_a, x_a, y_a, sol_a, sof_a, h_a, v_a,
               stab_a, ovf_a);
    check_inst(1, rst, de_b, hs_b, vs_b, d_b, x_b, y_b, sol_b, sof_b, h_b, v_b,
               stab_b, ovf_b);
  end

  // ---------------- stimulus ----------------
  int vs_left = 0;

  task automatic step(input bit de_v, input bit hs_v, input logic [23:0] dv);
    de = de_v; hs = hs_v; d = de_v ? dv : 24'd0;
    vs = (vs_left > 0);
    if (vs_left > 0) vs_left--;
    @(posedge clk); #1;
  endtask

  // mode 0: vs after the lines; 1: vs rises with the first pixel;
  // 2: vs rises with the de fall of the last line; 3: no vs.
  task automatic frame(input int w, input int h, input int mode);
    for (int l = 0; l < h; l++) begin
      int g;
      g = $urandom_range(1, 3);
      for (int k = 0; k < g; k++) step(0, k == 0, 0);
      for (int p = 0; p < w; p++) begin
        if (mode == 1 && l == 0 && p == 0) vs_left = 2;
        step(1, 0, 24'($urandom));
      end
    end
    if (mode == 0) step(0, 0, 0);
    if (mode == 0 || mode == 2) vs_left = 2;
    for (int k = 0; k < 4; k++) step(0, 0, 0);
  endtask

  initial begin
    int pw, ph, w, h, mode;
    rst = 0; de = 0; hs = 0; vs = 0; d = 0;
    #2 rst = 1;
    @(posedge clk); #1;
    chk("rst_de", de_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_stable", stab_a, 0);
    @(posedge clk); #1;
    rst = 0;
    for (int k = 0; k < 3; k++) step(0, 0, 0);

    // Single pixel: visible two edges after it is presented.
    step(1, 0, 24'hABCDEF);
    step(0, 0, 0);
    chk("px_d", d_a, 24'hABCDEF);
    chk("px_de", de_a, 1);
    chk("px_x", x_a, 0);
    chk("px_sol", sol_a, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0);
    vs_left = 2;
    for (int k = 0; k < 4; k++) step(0, 0, 0);

    // Three 6x4 frames, vs after each.
    frame(6, 4, 0);
    frame(6, 4, 0);
    chk("f2_h", h_a, 6);
    chk("f2_v", v_a, 4);
    chk("f2_stable", stab_a, 0);
    frame(6, 4, 0);
    chk("f3_stable", stab_a, 1);

    // A 5x4 frame drops stable on the edge that registers the vs rise.
    frame(5, 4, 3);
    step(0, 0, 0);
    vs_left = 2;
    step(0, 0, 0);
    chk("chg_stable_before", stab_a, 1);
    step(0, 0, 0);
    chk("chg_vs", vs_a, 1);
    chk("chg_stable_after", stab_a, 0);
    chk("chg_h", h_a, 5);
    for (int k = 0; k < 3; k++) step(0, 0, 0);

    // 10-pixel line on the 3-bit instance: x sticks at 7, ovf latches.
    chk("narrow_ovf_pre", ovf_b, 0);
    for (int i = 0; i <= 10; i++) begin
      step(i < 10, 0, 24'($urandom));
      if (i >= 8) chk($sformatf("narrow_x_px%0d", i - 1), x_b, 7);
    end
    chk("narrow_ovf", ovf_b, 1);
    for (int k = 0; k < 5; k++) step(0, 0, 0);
    chk("narrow_ovf_held", ovf_b, 1);

    // vs rise and de rise in the same cycle.
    step(0, 0, 0);
    vs_left = 2;
    step(1, 0, 24'h123456);
    step(1, 0, 24'h654321);
    chk("coin_sof", sof_a, 1);
    chk("coin_y", y_a, 0);
    chk("coin_x", x_a, 0);
    for (int k = 0; k < 3; k++) step(1, 0, 24'($urandom));
    for (int k = 0; k < 3; k++) step(0, 0, 0);

    // Reset in the middle of a line.
    step(0, 1, 0);
    for (int k = 0; k < 3; k++) step(1, 0, 24'($urandom));
    rst = 1;
    #1;
    chk("mid_rst_de", de_a, 0);
    chk("mid_rst_d", d_a, 0);
    chk("mid_rst_h", h_a, 0);
    chk("mid_rst_ovf_narrow", ovf_b, 0);
    @(posedge clk); #1;
    rst = 0;
    vs_left = 0;
    frame(6, 4, 0);
    frame(6, 4, 0);
    chk("post_rst_stable", stab_a, 0);
    frame(6, 4, 0);
    chk("post_rst_stable3", stab_a, 1);

    // Random frames, boundary coincidences and occasional resets.
    pw = 6; ph = 4;
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 2) == 0) begin w = pw; h = ph; end
      else begin w = $urandom_range(1, 12); h = $urandom_range(1, 9); end
      mode = $urandom_range(0, 3);
      frame(w, h, mode);
      if (mode == 3 && $urandom_range(0, 1) == 1) begin
        rst = 1;
        step(0, 0, 0);
        rst = 0;
        vs_left = 0;
      end
      pw = w; ph = h;
    end
    for (int k = 0; k < 4; k++) step(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
